// File: rtl/victim_cache_ctrl.sv
// rtl/victim_cache_ctrl.sv - sequencing controller for a 4-entry fully associative victim cache
//
// Handles one L1 miss at a time:
//   probe victim cache -> (miss) read line from memory -> return line to L1
//   -> insert the L1-evicted line -> write back any line the insert ejected.
// Also keeps saturating hit/miss statistics counters.
//
// Ports:
//   CLK, RST_N                    clock, asynchronous active-low reset
//   miss_valid/miss_ready         L1 miss handshake, miss_addr is a byte address
//   evict_valid/addr/data         line evicted by L1, sampled together with the miss
//   vc_lookup/vc_addr             victim probe strobe and line address
//   vc_hit/vc_data                probe result, one cycle after vc_lookup
//   vc_insert/vc_wdata            insert strobe and data (vc_addr holds the line address)
//   vc_eject_valid/addr/data      line displaced by the insert
//   mem_req/we/addr/wdata         memory request, held until mem_ack
//   mem_ack/mem_rdata             memory completion and read data
//   resp_valid/data/from_victim   one-cycle line return to L1
//   hit_count/miss_count          saturating statistics
module victim_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              evict_valid,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  output logic              miss_ready,
  output logic              vc_lookup,
  output logic [ADDR_W-1:0] vc_addr,
  input  logic              vc_hit,
  input  logic [LINE_W-1:0] vc_data,
  output logic              vc_insert,
  output logic [LINE_W-1:0] vc_wdata,
  input  logic              vc_eject_valid,
  input  logic [ADDR_W-1:0] vc_eject_addr,
  input  logic [LINE_W-1:0] vc_eject_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_from_victim,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  typedef enum logic [2:0] {
    IDLE, PROBE, WAIT_HIT, MEM_RD, RESP, INSERT, WB
  } state_t;

  // Clears the 5 byte-offset bits of a 32-byte line.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(31);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t              state;
  logic [ADDR_W-1:0]   miss_line;
  logic                ev_valid;
  logic [ADDR_W-1:0]   ev_line;
  logic [LINE_W-1:0]   ev_data;

  // All outputs are registered; each transition sets the outputs of the
  // state being entered, so strobes line up exactly with their state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state            <= IDLE;
      miss_line        <= '0;
      ev_valid         <= 1'b0;
      ev_line          <= '0;
      ev_data          <= '0;
      miss_ready       <= 1'b1;
      vc_lookup        <= 1'b0;
      vc_addr          <= '0;
      vc_insert        <= 1'b0;
      vc_wdata         <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_from_victim <= 1'b0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else begin
      vc_lookup  <= 1'b0;
      vc_insert  <= 1'b0;
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (miss_valid) begin
            miss_line  <= miss_addr & LINE_MASK;
            ev_valid   <= evict_valid;
            ev_line    <= evict_addr & LINE_MASK;
            ev_data    <= evict_data;
            miss_ready <= 1'b0;
            vc_lookup  <= 1'b1;
            vc_addr    <= miss_addr & LINE_MASK;
            state      <= PROBE;
          end
        end
        PROBE: state <= WAIT_HIT;
        WAIT_HIT: begin
          if (vc_hit) begin
            resp_valid       <= 1'b1;
            resp_data        <= vc_data;
            resp_from_victim <= 1'b1;
            if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
            state            <= RESP;
          end else begin
            resp_from_victim <= 1'b0;
            if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
            mem_req          <= 1'b1;
            mem_we           <= 1'b0;
            mem_addr         <= miss_line;
            state            <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= mem_rdata;
            state      <= RESP;
          end
        end
        RESP: begin
          if (ev_valid) begin
            vc_insert <= 1'b1;
            vc_addr   <= ev_line;
            vc_wdata  <= ev_data;
            state     <= INSERT;
          end else begin
            miss_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        INSERT: begin
          if (vc_eject_valid) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= vc_eject_addr & LINE_MASK;
            mem_wdata <= vc_eject_data;
            state     <= WB;
          end else begin
            miss_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        WB: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            miss_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// tb/tb_victim_cache_ctrl.sv - self-checking bench for victim_cache_ctrl
module tb_victim_cache_ctrl;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         evict_valid = 1'b0;
  logic [31:0]  evict_addr = '0;
  logic [255:0] evict_data = '0;
  logic         miss_ready;
  logic         vc_lookup;
  logic [31:0]  vc_addr;
  logic         vc_hit = 1'b0;
  logic [255:0] vc_data = '0;
  logic         vc_insert;
  logic [255:0] vc_wdata;
  logic         vc_eject_valid = 1'b0;
  logic [31:0]  vc_eject_addr = '0;
  logic [255:0] vc_eject_data = '0;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_ack = 1'b0;
  logic [255:0] mem_rdata = '0;
  logic         resp_valid;
  logic [255:0] resp_data;
  logic         resp_from_victim;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  // Narrow-counter copy sharing every input, used for saturation.
  logic         s_miss_ready, s_vc_lookup, s_vc_insert, s_mem_req, s_mem_we;
  logic         s_resp_valid, s_resp_from_victim;
  logic [31:0]  s_vc_addr, s_mem_addr;
  logic [255:0] s_vc_wdata, s_mem_wdata, s_resp_data;
  logic [1:0]   s_hit_count, s_miss_count;

  always #5 CLK = ~CLK;

  victim_cache_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .miss_ready(miss_ready),
    .vc_lookup(vc_lookup), .vc_addr(vc_addr),
    .vc_hit(vc_hit), .vc_data(vc_data),
    .vc_insert(vc_insert), .vc_wdata(vc_wdata),
    .vc_eject_valid(vc_eject_valid), .vc_eject_addr(vc_eject_addr), .vc_eject_data(vc_eject_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_from_victim(resp_from_victim),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  victim_cache_ctrl #(.CNT_W(2)) dut_sat (
    .CLK(CLK), .RST_N(RST_N),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
    .miss_ready(s_miss_ready),
    .vc_lookup(s_vc_lookup), .vc_addr(s_vc_addr),
    .vc_hit(vc_hit), .vc_data(vc_data),
    .vc_insert(s_vc_insert), .vc_wdata(s_vc_wdata),
    .vc_eject_valid(vc_eject_valid), .vc_eject_addr(vc_eject_addr), .vc_eject_data(vc_eject_data),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(s_resp_valid), .resp_data(s_resp_data), .resp_from_victim(s_resp_from_victim),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  typedef struct {
    logic [31:0]  addr;
    logic         hit;
    logic [255:0] vdata;
    int           lat;
    logic [255:0] rdata;
    logic         ev;
    logic [31:0]  ev_addr;
    logic [255:0] ev_data;
    logic         ej;
    logic [31:0]  ej_addr;
    logic [255:0] ej_data;
    int           wb_lat;
    logic         hold;
    logic [31:0]  exp_line;
    logic         exp_victim;
  } txn_t;

  int checks = 0;
  int failures = 0;
  int hits = 0;
  int misses = 0;
  int pulses = 0;

  always @(posedge CLK) if (resp_valid === 1'b1) pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % 32);
  endfunction

  task automatic check_counts();
    check("hit_count", 256'(hit_count), 256'(sat(hits, 65535)));
    check("miss_count", 256'(miss_count), 256'(sat(misses, 65535)));
    check("sat_hit_count", 256'(s_hit_count), 256'(sat(hits, 3)));
    check("sat_miss_count", 256'(s_miss_count), 256'(sat(misses, 3)));
  endtask

  // Plays L1, victim cache and memory for one complete transaction.
  task automatic run_txn(input txn_t t);
    int budget = 0;
    while (miss_ready !== 1'b1 && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    check("ready_before_accept", 256'(miss_ready), 256'(1));
    miss_valid  = 1'b1;
    miss_addr   = t.addr;
    evict_valid = t.ev;
    evict_addr  = t.ev_addr;
    evict_data  = t.ev_data;
    @(negedge CLK);
    // Probe cycle: scramble inputs that must already be latched or ignored.
    if (t.hold) miss_addr = $urandom();
    else miss_valid = 1'b0;
    evict_valid    = 1'($urandom_range(0, 1));
    evict_addr     = $urandom();
    evict_data     = rnd_line();
    vc_hit         = 1'b1;
    mem_ack        = 1'($urandom_range(0, 1));
    vc_eject_valid = 1'b1;
    check("probe_lookup", 256'(vc_lookup), 256'(1));
    check("probe_addr", 256'(vc_addr), 256'(t.exp_line));
    check("probe_ready", 256'(miss_ready), 256'(0));
    @(negedge CLK);
    mem_ack        = 1'b0;
    vc_eject_valid = 1'b0;
    check("lookup_one_cycle", 256'(vc_lookup), 256'(0));
    vc_hit  = t.hit;
    vc_data = t.vdata;
    @(negedge CLK);
    vc_hit  = 1'b0;
    vc_data = rnd_line();
    if (t.hit) hits++;
    else begin
      misses++;
      for (int i = 0; i < t.lat; i++) begin
        check("rd_req", 256'(mem_req), 256'(1));
        check("rd_we", 256'(mem_we), 256'(0));
        check("rd_addr", 256'(mem_addr), 256'(t.exp_line));
        check("rd_no_resp", 256'(resp_valid), 256'(0));
        if (i == t.lat - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = t.rdata;
        end
        @(negedge CLK);
        mem_ack   = 1'b0;
        mem_rdata = rnd_line();
      end
    end
    check("resp_valid", 256'(resp_valid), 256'(1));
    check("resp_data", resp_data, t.hit ? t.vdata : t.rdata);
    check("resp_from_victim", 256'(resp_from_victim), 256'(t.exp_victim));
    check("resp_no_mem", 256'(mem_req), 256'(0));
    check_counts();
    @(negedge CLK);
    check("resp_one_cycle", 256'(resp_valid), 256'(0));
    if (t.ev) begin
      check("insert", 256'(vc_insert), 256'(1));
      check("insert_addr", 256'(vc_addr), 256'(line_of(t.ev_addr)));
      check("insert_data", vc_wdata, t.ev_data);
      check("insert_ready", 256'(miss_ready), 256'(0));
      vc_eject_valid = t.ej;
      vc_eject_addr  = t.ej_addr;
      vc_eject_data  = t.ej_data;
      @(negedge CLK);
      vc_eject_valid = 1'b0;
      check("insert_one_cycle", 256'(vc_insert), 256'(0));
      if (t.ej) begin
        for (int i = 0; i < t.wb_lat; i++) begin
          check("wb_req", 256'(mem_req), 256'(1));
          check("wb_we", 256'(mem_we), 256'(1));
          check("wb_addr", 256'(mem_addr), 256'(line_of(t.ej_addr)));
          check("wb_data", mem_wdata, t.ej_data);
          if (i == t.wb_lat - 1) mem_ack = 1'b1;
          @(negedge CLK);
          mem_ack = 1'b0;
        end
      end
    end
    check("end_ready", 256'(miss_ready), 256'(1));
    check("end_no_req", 256'(mem_req), 256'(0));
  endtask

  txn_t tbl[6];
  txn_t t;
  int p0;

  initial begin
    tbl[0] = '{32'h0000_1234, 1'b1, {32{8'hAB}}, 1, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1, 1'b0,
               32'h0000_1220, 1'b1};
    tbl[1] = '{32'h0000_1234, 1'b0, '0, 5, {8{32'hDEAD_BEEF}}, 1'b0, '0, '0, 1'b0, '0, '0, 1, 1'b0,
               32'h0000_1220, 1'b0};
    tbl[2] = '{32'h2000_001F, 1'b0, '0, 1, {16{16'h5A5A}}, 1'b1, 32'h0000_4040, {8{32'h1111_2222}},
               1'b1, 32'h0000_8000, {8{32'h3333_4444}}, 3, 1'b0, 32'h2000_0000, 1'b0};
    tbl[3] = '{32'h0000_4044, 1'b1, {8{32'hCAFE_F00D}}, 1, '0, 1'b1, 32'h0000_4040, {8{32'h7777_8888}},
               1'b0, '0, '0, 1, 1'b0, 32'h0000_4040, 1'b1};
    tbl[4] = '{32'h0001_0008, 1'b1, {8{32'h0102_0304}}, 1, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1, 1'b1,
               32'h0001_0000, 1'b1};
    tbl[5] = '{32'h0002_0030, 1'b0, '0, 2, {8{32'h0A0B_0C0D}}, 1'b1, 32'h0003_0021, {8{32'h9999_0000}},
               1'b0, '0, '0, 1, 1'b1, 32'h0002_0020, 1'b0};

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_ready", 256'(miss_ready), 256'(1));
    check("rst_lookup", 256'(vc_lookup), 256'(0));
    check("rst_insert", 256'(vc_insert), 256'(0));
    check("rst_mem_req", 256'(mem_req), 256'(0));
    check("rst_resp", 256'(resp_valid), 256'(0));
    check("rst_vc_addr", 256'(vc_addr), 256'(0));
    check_counts();
    RST_N = 1'b1;
    @(negedge CLK);

    // Directed table; rows 4-5 keep miss_valid high back to back.
    p0 = pulses;
    for (int i = 0; i < 6; i++) run_txn(tbl[i]);
    miss_valid = 1'b0;
    @(negedge CLK);
    check("table_resp_pulses", 256'(pulses - p0), 256'(6));
    check("idle_after_table", 256'(miss_ready), 256'(1));

    // Reset in the middle of a memory read
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_1234;
    evict_valid = 1'b0;
    @(negedge CLK);
    miss_valid = 1'b0;
    @(negedge CLK);
    vc_hit = 1'b0;
    @(negedge CLK);
    misses++;
    check("midrst_req_before", 256'(mem_req), 256'(1));
    check("midrst_miss_before", 256'(miss_count), 256'(sat(misses, 65535)));
    #1 RST_N = 1'b0;
    #1;
    check("midrst_req_drop", 256'(mem_req), 256'(0));
    check("midrst_ready", 256'(miss_ready), 256'(1));
    hits = 0;
    misses = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_counts();
    check("midrst_idle_req", 256'(mem_req), 256'(0));

    // Five hits: narrow counter stops at 3
    for (int i = 0; i < 5; i++) begin
      t = tbl[0];
      t.addr = $urandom();
      t.exp_line = line_of(t.addr);
      t.vdata = rnd_line();
      run_txn(t);
    end
    check("sat_hit_stop", 256'(s_hit_count), 256'(3));
    check("wide_hit_five", 256'(hit_count), 256'(5));

    // Randomized transactions against the transaction-level model
    for (int i = 0; i < 60; i++) begin
      t.addr       = $urandom();
      t.hit        = 1'($urandom_range(0, 1));
      t.vdata      = rnd_line();
      t.lat        = $urandom_range(1, 6);
      t.rdata      = rnd_line();
      t.ev         = 1'($urandom_range(0, 1));
      t.ev_addr    = $urandom();
      t.ev_data    = rnd_line();
      t.ej         = 1'($urandom_range(0, 1));
      t.ej_addr    = $urandom();
      t.ej_data    = rnd_line();
      t.wb_lat     = $urandom_range(1, 4);
      t.hold       = 1'($urandom_range(0, 1));
      t.exp_line   = line_of(t.addr);
      t.exp_victim = t.hit;
      run_txn(t);
    end
    miss_valid = 1'b0;
    @(negedge CLK);
    check("final_idle", 256'(miss_ready), 256'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
